// File: rtl/device_delay_pkg.sv
// Shared types and elaboration helpers for the programmable millisecond delay timer.
package device_delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } DELAY_STATES;

  localparam int FREQ_STEP_HZ = 1000;
  localparam int FREQ_MIN_HZ  = 2000;

  function automatic int ticks_per_ms(input int freq);
    return freq / FREQ_STEP_HZ;
  endfunction

  function automatic bit freq_is_valid(input int freq);
    return ((freq % FREQ_STEP_HZ) == 0) && (freq >= FREQ_MIN_HZ);
  endfunction

endpackage

// File: rtl/device_delay_prog_ms_tick_gen.sv
// Millisecond prescaler: o_tick is high for the one cycle whose edge completes a millisecond.
module ms_tick_gen #(
  parameter int TICKS_PER_MS = 4
) (
  input  logic clk_i,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int PRESCALE_WIDTH = $clog2(TICKS_PER_MS);

  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      w_at_top;

  assign w_at_top = (r_prescale == PRESCALE_WIDTH'(TICKS_PER_MS - 1));
  assign o_tick   = i_enable && w_at_top;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_prescale <= '0;
    end else if (i_clear) begin
      r_prescale <= '0;
    end else if (i_enable) begin
      r_prescale <= w_at_top ? '0 : r_prescale + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/device_delay_prog.sv
// Runtime-programmable ms delay timer with one-shot/periodic modes, abort and retrigger.
// Define DEVICE_DELAY_REMAINING_EN to add the remaining_ms_o countdown output.
module device_delay_prog
  import device_delay_pkg::*;
#(
  parameter int MAIN_CLOCK_FREQUENCY = 27_000_000,
  parameter int DELAY_WIDTH          = 16
) (
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [DELAY_WIDTH-1:0] delay_ms_i,
  input  logic                   periodic_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   done_pulse_o
`ifdef DEVICE_DELAY_REMAINING_EN
  ,
  output logic [DELAY_WIDTH-1:0] remaining_ms_o
`endif
);

  localparam int TICKS_PER_MS = ticks_per_ms(MAIN_CLOCK_FREQUENCY);

  if (!freq_is_valid(MAIN_CLOCK_FREQUENCY)) begin : g_freq_check
    $error("MAIN_CLOCK_FREQUENCY must be a multiple of 1000 and at least 2000");
  end

  DELAY_STATES            r_state, w_state_nxt;
  logic [DELAY_WIDTH-1:0] r_remaining, w_remaining_nxt;
  logic [DELAY_WIDTH-1:0] r_reload, w_reload_nxt;
  logic                   r_periodic, w_periodic_nxt;
  logic                   r_busy, r_done, w_done_nxt;
  logic                   r_pulse, w_pulse_nxt;
  logic                   w_ms_tick;
  logic                   w_clear;

  // Any start or abort restarts the millisecond phase from zero.
  assign w_clear = start_i || abort_i;

  ms_tick_gen #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_tick (
    .clk_i   (clk_i),
    .rst     (rst),
    .i_clear (w_clear),
    .i_enable(r_state == COUNT),
    .o_tick  (w_ms_tick)
  );

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_reload    <= '0;
      r_periodic  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pulse     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_reload    <= w_reload_nxt;
      r_periodic  <= w_periodic_nxt;
      r_busy      <= (w_state_nxt == COUNT);
      r_done      <= w_done_nxt;
      r_pulse     <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_reload_nxt    = r_reload;
    w_periodic_nxt  = r_periodic;
    w_done_nxt      = r_done;
    w_pulse_nxt     = 1'b0;
    if (abort_i) begin
      w_state_nxt     = IDLE;
      w_remaining_nxt = '0;
      w_done_nxt      = 1'b0;
    end else if (start_i) begin
      // A zero delay expires on the accepting edge and never repeats.
      w_reload_nxt    = delay_ms_i;
      w_periodic_nxt  = periodic_i && (delay_ms_i != '0);
      w_remaining_nxt = delay_ms_i;
      w_done_nxt      = (delay_ms_i == '0);
      w_pulse_nxt     = (delay_ms_i == '0);
      w_state_nxt     = (delay_ms_i == '0) ? DONE : COUNT;
    end else if ((r_state == COUNT) && w_ms_tick) begin
      if (r_remaining == DELAY_WIDTH'(1)) begin
        w_pulse_nxt = 1'b1;
        if (r_periodic) begin
          w_remaining_nxt = r_reload;
        end else begin
          w_remaining_nxt = '0;
          w_state_nxt     = DONE;
          w_done_nxt      = 1'b1;
        end
      end else begin
        w_remaining_nxt = r_remaining - DELAY_WIDTH'(1);
      end
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign done_pulse_o = r_pulse;

`ifdef DEVICE_DELAY_REMAINING_EN
  logic [DELAY_WIDTH-1:0] r_remaining_ms;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_remaining_ms <= '0;
    end else begin
      r_remaining_ms <= (w_state_nxt == COUNT) ? w_remaining_nxt : '0;
    end
  end

  assign remaining_ms_o = r_remaining_ms;
`endif

endmodule

// File: tb/tb_device_delay_prog.sv
// Self-checking bench for device_delay_prog: vector table, timed corner sequences and random traffic.
module tb_device_delay_prog;

  localparam int FREQ = 4000;
  localparam int DW   = 8;
  localparam int T    = FREQ / 1000;

  logic          clk_i = 1'b0;
  logic          rst   = 1'b1;
  logic          start_i = 1'b0;
  logic [DW-1:0] delay_ms_i = '0;
  logic          periodic_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          busy_o, done_o, done_pulse_o;
`ifdef DEVICE_DELAY_REMAINING_EN
  logic [DW-1:0] remaining_ms_o;
`endif

  device_delay_prog #(
    .MAIN_CLOCK_FREQUENCY(FREQ),
    .DELAY_WIDTH(DW)
  ) dut (
    .clk_i       (clk_i),
    .rst         (rst),
    .start_i     (start_i),
    .delay_ms_i  (delay_ms_i),
    .periodic_i  (periodic_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .done_pulse_o(done_pulse_o)
`ifdef DEVICE_DELAY_REMAINING_EN
    ,
    .remaining_ms_o(remaining_ms_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: tracks the absolute cycle at which the next expiry is due.
  int m_cyc      = 0;
  bit m_busy     = 0;
  bit m_done     = 0;
  bit m_pulse    = 0;
  bit m_periodic = 0;
  int m_deadline = 0;
  int m_period   = 0;
  int pulse_log[$];

  typedef struct {
    logic          s;
    logic [DW-1:0] d;
    logic          p;
    logic          a;
    logic          eb;
    logic          ed;
    logic          ep;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, m_cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy  = 0;
    m_done  = 0;
    m_pulse = 0;
  endfunction

  function automatic void model_edge(input logic s, input logic [DW-1:0] d, input logic p, input logic a);
    m_cyc++;
    m_pulse = 0;
    if (a) begin
      m_busy = 0;
      m_done = 0;
    end else if (s) begin
      if (d == 0) begin
        m_busy = 0;
        m_done = 1;
        m_pulse = 1;
      end else begin
        m_busy     = 1;
        m_done     = 0;
        m_period   = int'(d) * T;
        m_deadline = m_cyc + m_period;
        m_periodic = p;
      end
    end else if (m_busy && m_cyc == m_deadline) begin
      m_pulse = 1;
      if (m_periodic) m_deadline += m_period;
      else begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endfunction

  function automatic int model_remaining();
    return m_busy ? (m_deadline - m_cyc + T - 1) / T : 0;
  endfunction

  task automatic step(input logic s, input logic [DW-1:0] d, input logic p, input logic a);
    start_i    = s;
    delay_ms_i = d;
    periodic_i = p;
    abort_i    = a;
    @(posedge clk_i);
    model_edge(s, d, p, a);
    #1;
    chk("busy", 32'(busy_o), 32'(m_busy));
    chk("done", 32'(done_o), 32'(m_done));
    chk("pulse", 32'(done_pulse_o), 32'(m_pulse));
`ifdef DEVICE_DELAY_REMAINING_EN
    chk("remaining", 32'(remaining_ms_o), 32'(model_remaining()));
`endif
    if (done_pulse_o) pulse_log.push_back(m_cyc);
    start_i = 0;
    abort_i = 0;
    periodic_i = 0;
    delay_ms_i = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0);
  endtask

  initial begin
    int base;
    int exp_per[3];
    exp_per = '{8, 16, 24};

    tbl[0] = '{s:1, d:0, p:0, a:0, eb:0, ed:1, ep:1};
    tbl[1] = '{s:0, d:0, p:0, a:0, eb:0, ed:1, ep:0};
    tbl[2] = '{s:1, d:3, p:0, a:1, eb:0, ed:0, ep:0};
    tbl[3] = '{s:1, d:1, p:0, a:0, eb:1, ed:0, ep:0};
    tbl[4] = '{s:0, d:0, p:0, a:0, eb:1, ed:0, ep:0};
    tbl[5] = '{s:0, d:0, p:0, a:0, eb:1, ed:0, ep:0};
    tbl[6] = '{s:0, d:0, p:0, a:0, eb:1, ed:0, ep:0};
    tbl[7] = '{s:0, d:0, p:0, a:0, eb:0, ed:1, ep:1};
    tbl[8] = '{s:0, d:0, p:0, a:0, eb:0, ed:1, ep:0};
    tbl[9] = '{s:0, d:0, p:0, a:1, eb:0, ed:0, ep:0};

    #12;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_pulse", 32'(done_pulse_o), 0);
`ifdef DEVICE_DELAY_REMAINING_EN
    chk("rst_remaining", 32'(remaining_ms_o), 0);
`endif
    @(negedge clk_i);
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s, tbl[i].d, tbl[i].p, tbl[i].a);
      chk("tbl_busy", 32'(busy_o), 32'(tbl[i].eb));
      chk("tbl_done", 32'(done_o), 32'(tbl[i].ed));
      chk("tbl_pulse", 32'(done_pulse_o), 32'(tbl[i].ep));
    end

    // One-shot, 3 ms.
    pulse_log.delete();
    step(1, 3, 0, 0);
    base = m_cyc;
    for (int k = 1; k <= 32; k++) begin
      step(0, '0, 0, 0);
`ifdef DEVICE_DELAY_REMAINING_EN
      if (k == 3) chk("rem_k3", 32'(remaining_ms_o), 3);
      if (k == 4) chk("rem_k4", 32'(remaining_ms_o), 2);
      if (k == 8) chk("rem_k8", 32'(remaining_ms_o), 1);
      if (k == 12) chk("rem_k12", 32'(remaining_ms_o), 0);
`endif
      if (k == 11) chk("os_busy_k11", 32'(busy_o), 1);
      if (k == 12) chk("os_busy_k12", 32'(busy_o), 0);
    end
    chk("os_npulse", 32'(pulse_log.size()), 1);
    if (pulse_log.size() >= 1) chk("os_pulse_cyc", 32'(pulse_log[0] - base), 12);
    chk("os_done_held", 32'(done_o), 1);

    // Periodic, 2 ms, aborted at cycle 26.
    pulse_log.delete();
    step(1, 2, 1, 0);
    base = m_cyc;
    idle(25);
    step(0, '0, 0, 1);
    chk("per_abort_busy", 32'(busy_o), 0);
    idle(12);
    chk("per_npulse", 32'(pulse_log.size()), 3);
    for (int i = 0; i < 3 && i < pulse_log.size(); i++)
      chk("per_pulse_cyc", 32'(pulse_log[i] - base), 32'(exp_per[i]));

    // Retrigger: 5 ms restarted with 1 ms at cycle 10.
    pulse_log.delete();
    step(1, 5, 0, 0);
    base = m_cyc;
    idle(9);
    step(1, 1, 0, 0);
    idle(15);
    chk("rt_npulse", 32'(pulse_log.size()), 1);
    if (pulse_log.size() >= 1) chk("rt_pulse_cyc", 32'(pulse_log[0] - base), 14);

    // Start coinciding with expiry.
    pulse_log.delete();
    step(1, 1, 0, 0);
    base = m_cyc;
    idle(3);
    step(1, 2, 0, 0);
    chk("col_no_pulse", 32'(done_pulse_o), 0);
    chk("col_busy", 32'(busy_o), 1);
    idle(10);
    chk("col_npulse", 32'(pulse_log.size()), 1);
    if (pulse_log.size() >= 1) chk("col_pulse_cyc", 32'(pulse_log[0] - base), 12);

    // Async reset at cycle 6 of a 3 ms delay.
    pulse_log.delete();
    step(1, 3, 0, 0);
    idle(6);
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_done", 32'(done_o), 0);
    chk("arst_pulse", 32'(done_pulse_o), 0);
`ifdef DEVICE_DELAY_REMAINING_EN
    chk("arst_remaining", 32'(remaining_ms_o), 0);
`endif
    #1;
    rst = 0;
    idle(20);
    chk("arst_npulse", 32'(pulse_log.size()), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic s, a, p;
      logic [DW-1:0] d;
      s = ($urandom_range(0, 15) == 0);
      a = ($urandom_range(0, 31) == 0);
      p = 1'($urandom_range(0, 1));
      d = DW'($urandom_range(0, 4));
      step(s, d, p, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
